cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Arbitrates result broadcasts from NREQ execution units (ALU, LSB, …) onto the single common data bus (CDB).
- The CDB feeds the ROB, RS, LSB and register-file forwarding paths.
- Each requester owns a one-entry holding slot. A round-robin arbiter grants one slot per cycle, and the winner is driven on a registered CDB output.
- A ROB clear (branch mispredict) flushes all held results.

Parameters:
NREQ, 2, number of requesting units (≥2)
ROBW, 4, width of a ROB entry name (matches ROBID width)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
rdy  input  1  global ready; low = freeze all state
clr  input  1  ROB clear / flush (synchronous)
req_valid  input  NREQ  requester i has a result
req_rob  input  NREQ*ROBW  ROB name of requester i, slice [i*ROBW +: ROBW]
req_val  input  NREQ*32  result value of requester i, slice [i*32 +: 32]
req_ready  output  NREQ  slot i can accept this cycle
cdb_valid  output  1  broadcast valid
cdb_rob  output  ROBW  ROB name broadcast
cdb_val  output  32  value broadcast

Behaviour:
Reset
- rst high (asynchronous) clears: all hold_valid, ptr=0, cdb_valid=0, cdb_rob=0, cdb_val=0.
- Reset mid-operation discards held results without a broadcast.

Storage
- Per slot i: hold_valid[i], hold_rob[i], hold_val[i].
- Pointer ptr in [0, NREQ-1].

Grant (combinational)
- Candidate set = slots with hold_valid=1.
- grant = the first candidate scanning ptr, ptr+1, …, NREQ-1, 0, …, ptr-1. One-hot or zero.

Ready (combinational)
- req_ready[i] = rdy && !clr && (!hold_valid[i] || grant[i]).
- A slot being broadcast this cycle can refill in the same cycle, so one result per cycle per requester is sustainable when uncontended.

Clock edge, rdy=1, clr=0
- If any grant:
  - cdb_valid<=1; cdb_rob/cdb_val <= granted slot contents.
  - Granted hold_valid cleared.
  - ptr <= (granted index + 1) mod NREQ.
- Otherwise cdb_valid<=0; cdb_rob/cdb_val hold their old values and are don't-care.
- For each i with req_valid[i] && req_ready[i]: hold_* <= request.
- A same-cycle refill of the granted slot sets hold_valid back to 1.
- ptr is unchanged when there is no grant.

Clock edge, rdy=1, clr=1
- clr dominates: all hold_valid<=0, cdb_valid<=0, ptr<=0.
- Requests in that cycle are not accepted (req_ready=0).

Clock edge, rdy=0
- All state frozen, including cdb_* outputs.
- req_ready=0.
- clr is ignored.

Latency
- Accept at edge t, broadcast visible from edge t+1 when the slot wins, i.e. cdb_valid is high the cycle after the accepting cycle.
- Worst-case wait for a held slot is NREQ-1 further cycles, since round-robin guarantees no starvation.

Ordering
- Per requester, results broadcast in acceptance order (single slot).
- No ordering guarantee across requesters.

Widths
- ROB names are passed unmodified.
- ptr has width clog2(NREQ) (minimum 1) and wraps modulo NREQ. The NREQ non-power-of-two wrap must be explicit.

cdb_valid
- High for exactly one cycle per broadcast.
- No duplicate broadcast of a slot.

Test Plan:
- Reset, then idle (NREQ=2): cdb_valid=0, req_ready=2'b11, ptr=0. Assert rst asynchronously mid-cycle while slot 0 is held → cdb_valid=0 immediately, and no broadcast after release.
- Single requester streaming: req_valid[0]=1 for 4 cycles with rob 1..4, vals 0x10..0x13 → cdb shows (1,0x10),(2,0x11),(3,0x12),(4,0x13) on 4 consecutive cycles starting one cycle after the first accept; req_ready[0] stays 1.
- Contention: both slots held, slot0 (rob 5, 0xA), slot1 (rob 6, 0xB), ptr=0 → cycle1 broadcasts rob5 and ptr=1; cycle2 broadcasts rob6 and ptr=0. While slot1 waits with a new req_valid[1], req_ready[1]=0.
- Fairness: both requesters continuously valid for 8 cycles → broadcasts alternate 0,1,0,1,…, 4 each, no starvation.
- Flush: slots 0 and 1 held, clr=1 for one cycle with req_valid=2'b11 → next cycle cdb_valid=0, both slots empty, nothing accepted, ptr=0. The following cycle accepts normally.
- Stall: slot0 held, cdb_valid=1 showing rob 7, then rdy=0 for 3 cycles → cdb_* unchanged, req_ready=0, no new broadcast. After rdy=1, slot0 broadcasts once.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, round-robin
// grant of one slot per cycle onto a registered CDB broadcast.
module cdb_arbiter #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned ROBW = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*ROBW-1:0] req_rob,
  input  logic [NREQ*32-1:0]   req_val,
  output logic [NREQ-1:0]      req_ready,
  output logic                 cdb_valid,
  output logic [ROBW-1:0]      cdb_rob,
  output logic [31:0]          cdb_val
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] hold_valid_q;
  logic [ROBW-1:0] hold_rob_q [NREQ];
  logic [31:0]     hold_val_q [NREQ];
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] ptr_d;

  logic            cdb_valid_q;
  logic [ROBW-1:0] cdb_rob_q;
  logic [31:0]     cdb_val_q;

  logic [NREQ-1:0] grant;
  logic [PtrW-1:0] grant_idx;
  logic            any_grant;
  logic [PtrW:0]   scan_sum;
  logic [PtrW-1:0] scan_idx;

  // Round-robin scan starting at ptr; the extra sum bit keeps the
  // modulo-NREQ wrap correct when NREQ is not a power of two.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      scan_sum = {1'b0, ptr_q} + (PtrW+1)'(k);
      if (scan_sum >= (PtrW+1)'(NREQ)) begin
        scan_sum = scan_sum - (PtrW+1)'(NREQ);
      end
      scan_idx = scan_sum[PtrW-1:0];
      if (!any_grant && hold_valid_q[scan_idx]) begin
        any_grant        = 1'b1;
        grant[scan_idx]  = 1'b1;
        grant_idx        = scan_idx;
      end
    end
  end

  // Pointer advances past the winner, wrapping explicitly at NREQ-1.
  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      if (grant_idx == PtrW'(NREQ - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx + PtrW'(1);
      end
    end
  end

  // A slot being broadcast this cycle may refill in the same cycle.
  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      req_ready[i] = rdy && !clr && (!hold_valid_q[i] || grant[i]);
    end
  end

  // Slot, pointer and broadcast registers; rdy=0 freezes everything, clr flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      ptr_q        <= '0;
      cdb_valid_q  <= 1'b0;
      cdb_rob_q    <= '0;
      cdb_val_q    <= '0;
      for (int i = 0; i < int'(NREQ); i++) begin
        hold_rob_q[i] <= '0;
        hold_val_q[i] <= '0;
      end
    end else if (rdy) begin
      if (clr) begin
        hold_valid_q <= '0;
        ptr_q        <= '0;
        cdb_valid_q  <= 1'b0;
      end else begin
        cdb_valid_q <= any_grant;
        ptr_q       <= ptr_d;
        if (any_grant) begin
          cdb_rob_q <= hold_rob_q[grant_idx];
          cdb_val_q <= hold_val_q[grant_idx];
        end
        for (int i = 0; i < int'(NREQ); i++) begin
          if (req_valid[i] && req_ready[i]) begin
            hold_valid_q[i] <= 1'b1;
            hold_rob_q[i]   <= req_rob[i*ROBW +: ROBW];
            hold_val_q[i]   <= req_val[i*32 +: 32];
          end else if (grant[i]) begin
            hold_valid_q[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_rob   = cdb_rob_q;
  assign cdb_val   = cdb_val_q;

endmodule
